// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
//   Captures a triggered burst of 256-bit ADC AXIS beats into block RAM, then
//   drains the burst as an out_width-bit AXIS stream (least-significant word
//   of each beat first). Single clock domain (pl_clk).
//
// Ports
//   pl_clk, rst          clock, asynchronous active-low reset
//   arm, trigger         level inputs; rising edges arm and start a capture
//   capture_len          beats to capture, sampled on the arm edge
//                        (0 or > mem_depth means mem_depth)
//   s_axis_*             256-bit ADC input stream (never back-pressured)
//   m_axis_*             out_width-bit output stream with tlast on the final word
//   busy                 high while ARMED, CAPTURE or DRAIN
//   done                 one-cycle pulse after the final word is accepted
//
// Build option
//   CAPTURE_TIMESTAMP_EN  when defined, a free-running 32-bit cycle counter is
//                         latched at the trigger edge and sent as one header
//                         word ahead of the data words.
module adc_capture_ctrl #(
    parameter int mem_depth = 1024,
    parameter int out_width = 32
) (
    input  logic                         pl_clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         trigger,
    input  logic [$clog2(mem_depth):0]   capture_len,
    input  logic [255:0]                 s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [out_width-1:0]         m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         busy,
    output logic                         done
);

    localparam int AW  = $clog2(mem_depth);
    localparam int LW  = AW + 1;
    localparam int WPB = 256 / out_width;
    localparam int WIW = (WPB > 1) ? $clog2(WPB) : 1;

    localparam logic [LW-1:0]  DEPTH = LW'(mem_depth);
    localparam logic [WIW-1:0] WLAST = WIW'(WPB - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic [1:0]     state_q, state_d;
    logic           arm_q, arm_prev_q, trg_q, trg_prev_q;
    logic           tready_q;
    logic [LW-1:0]  len_q, wr_cnt_q, rd_ptr_q, ld_cnt_q;
    logic           iss_q, pb_vld_q, ovld_q, olast_q, done_q;
    logic [WIW-1:0] widx_q;
    logic [255:0]   obeat_q, pb_q, ram_q;
    logic [255:0]   mem [mem_depth];

    logic           arm_edge, trg_edge, wr_en, wr_last, xfer, fin;
    logic           need, avail, load, load_hdr, issue;
    logic [255:0]   avail_data, hdr_word;
    logic [LW-1:0]  len_clamped;

    assign arm_edge = arm_q & ~arm_prev_q;
    assign trg_edge = trg_q & ~trg_prev_q;

    assign len_clamped = (capture_len == '0 || capture_len > DEPTH) ? DEPTH : capture_len;

    assign wr_en   = (state_q == ST_CAPTURE) && s_axis_tvalid;
    assign wr_last = wr_en && (wr_cnt_q == len_q - LW'(1));

    assign m_axis_tdata  = obeat_q[out_width-1:0];
    assign m_axis_tvalid = ovld_q;
    assign m_axis_tlast  = ovld_q && olast_q && (widx_q == WLAST);
    assign s_axis_tready = tready_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

    assign xfer = ovld_q && m_axis_tready;
    assign fin  = xfer && m_axis_tlast;

    // The output register wants a new beat when empty or when its final word
    // is leaving this cycle. At most one of {prefetch buffer, read in flight}
    // is ever occupied, so the next beat is always one of those two.
    assign need       = (state_q == ST_DRAIN) && (!ovld_q || (m_axis_tready && widx_q == WLAST));
    assign avail      = pb_vld_q | iss_q;
    assign avail_data = pb_vld_q ? pb_q : ram_q;
    assign load       = need && !load_hdr && avail;
    assign issue      = (state_q == ST_DRAIN) && (rd_ptr_q != len_q) && !iss_q && (!pb_vld_q || load);

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] cyc_q, ts_q;
    logic        hdr_pend_q;

    assign load_hdr = need && hdr_pend_q;
    assign hdr_word = {224'd0, ts_q};

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            cyc_q      <= '0;
            ts_q       <= '0;
            hdr_pend_q <= 1'b0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (state_q == ST_ARMED && trg_edge) ts_q <= cyc_q;
            if (state_q == ST_IDLE && arm_edge) hdr_pend_q <= 1'b1;
            else if (load_hdr)                  hdr_pend_q <= 1'b0;
        end
    end
`else
    assign load_hdr = 1'b0;
    assign hdr_word = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arm_edge) state_d = ST_ARMED;
            ST_ARMED:   if (trg_edge) state_d = ST_CAPTURE;
            ST_CAPTURE: if (wr_last)  state_d = ST_DRAIN;
            default:    if (fin)      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            arm_q      <= 1'b0;
            arm_prev_q <= 1'b0;
            trg_q      <= 1'b0;
            trg_prev_q <= 1'b0;
            tready_q   <= 1'b0;
            len_q      <= '0;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            ld_cnt_q   <= '0;
            iss_q      <= 1'b0;
            pb_vld_q   <= 1'b0;
            ovld_q     <= 1'b0;
            olast_q    <= 1'b0;
            widx_q     <= '0;
            obeat_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm;
            arm_prev_q <= arm_q;
            trg_q      <= trigger;
            trg_prev_q <= trg_q;
            tready_q   <= 1'b1;
            done_q     <= fin;

            if (state_q == ST_IDLE && arm_edge) begin
                len_q    <= len_clamped;
                wr_cnt_q <= '0;
                rd_ptr_q <= '0;
                ld_cnt_q <= '0;
            end
            if (wr_en) wr_cnt_q <= wr_cnt_q + LW'(1);

            iss_q <= issue;
            if (issue) rd_ptr_q <= rd_ptr_q + LW'(1);

            // Read data that cannot go straight to the output parks in the prefetch buffer.
            if (iss_q && !load)        pb_vld_q <= 1'b1;
            else if (pb_vld_q && load) pb_vld_q <= 1'b0;

            // The header is loaded as a one-word beat (index already at the last word).
            if (load_hdr) begin
                obeat_q <= hdr_word;
                widx_q  <= WLAST;
                ovld_q  <= 1'b1;
                olast_q <= 1'b0;
            end else if (load) begin
                obeat_q  <= avail_data;
                widx_q   <= '0;
                ovld_q   <= 1'b1;
                olast_q  <= (ld_cnt_q == len_q - LW'(1));
                ld_cnt_q <= ld_cnt_q + LW'(1);
            end else if (xfer) begin
                if (widx_q == WLAST) begin
                    ovld_q <= 1'b0;
                end else begin
                    widx_q  <= widx_q + WIW'(1);
                    obeat_q <= obeat_q >> out_width;
                end
            end
        end
    end

    always_ff @(posedge pl_clk) begin
        if (wr_en) mem[wr_cnt_q[AW-1:0]] <= s_axis_tdata;
        if (issue) ram_q <= mem[rd_ptr_q[AW-1:0]];
        if (iss_q && !load) pb_q <= ram_q;
    end

endmodule
